// File: rtl/logic_unit_seq.sv
// Multi-op bitwise logic unit processing WIDTH-bit operands CHUNK bits per clock; out_valid NCHUNK cycles after accept.
// in_ready only in IDLE (producer stalls); result is held in DONE until out_ready, with no accept on the drain edge.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("logic_unit_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] res_q;

    function automatic logic [CHUNK-1:0] slice_op(input logic [2:0]       o,
                                                  input logic [CHUNK-1:0] x,
                                                  input logic [CHUNK-1:0] y);
        case (o)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x ^ y;
            3'b011:  return ~(x & y);
            3'b100:  return ~(x | y);
            3'b101:  return ~(x ^ y);
            3'b110:  return x;
            default: return ~x;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            res_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        res_q <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Constant-index slice select keeps the write decode static per slice
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (cnt == CW'(k))
                            res_q[k*CHUNK +: CHUNK] <= slice_op(op_q, a_q[k*CHUNK +: CHUNK],
                                                                b_q[k*CHUNK +: CHUNK]);
                    end
                    if (cnt == LAST)
                        state <= S_DONE;
                    else
                        cnt <= cnt + CW'(1);
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign result    = out_valid ? res_q : '0;
    assign zero      = out_valid & ~(|res_q);

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench: three instances (CHUNK 8, 32, 1) driven in lockstep, checked with immediate assertions.
module tb_logic_unit_seq;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        out_ready;

    logic        in_rdy  [3];
    logic        out_vld [3];
    logic [31:0] res     [3];
    logic        zro     [3];

    int checks = 0;
    int errors = 0;
    int exp_lat [3] = '{4, 1, 32};

    logic_unit_seq #(.WIDTH(32), .CHUNK(8)) u_c8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[0]),
        .a(a), .b(b), .op(op), .out_valid(out_vld[0]), .out_ready(out_ready),
        .result(res[0]), .zero(zro[0]));
    logic_unit_seq #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[1]),
        .a(a), .b(b), .op(op), .out_valid(out_vld[1]), .out_ready(out_ready),
        .result(res[1]), .zero(zro[1]));
    logic_unit_seq #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[2]),
        .a(a), .b(b), .op(op), .out_valid(out_vld[2]), .out_ready(out_ready),
        .result(res[2]), .zero(zro[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Accepts one op on all three instances, measures latency, checks result/zero, optionally drains.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] expv, input bit drain);
        int lat [3];
        bit got [3];
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            got[i] = 1'b0;
        end
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        a        = 32'h0;
        b        = $urandom;
        op       = 3'($urandom);
        chk({tag, "_busy"}, 32'(in_rdy[0]), 32'd0);
        for (int c = 1; c <= 40; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (!got[i] && out_vld[i]) begin
                    got[i] = 1'b1;
                    lat[i] = c;
                end
            end
            if (got[0] && got[1] && got[2]) break;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_lat%0d", tag, i), 32'(lat[i]), 32'(exp_lat[i]));
            chk($sformatf("%s_res%0d", tag, i), res[i], expv);
            chk($sformatf("%s_zero%0d", tag, i), 32'(zro[i]), 32'(expv == 32'h0));
        end
        if (drain) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s_rdy%0d", tag, i), 32'(in_rdy[i]), 32'd1);
                chk($sformatf("%s_ovld%0d", tag, i), 32'(out_vld[i]), 32'd0);
                chk($sformatf("%s_res0_%0d", tag, i), res[i], 32'h0);
            end
        end
    endtask

    logic [31:0] sweep_exp [8] = '{32'h000F000F, 32'h0FFF0FFF, 32'h0FF00FF0, 32'hFFF0FFF0,
                                   32'hF000F000, 32'hF00FF00F, 32'h0F0F00FF, 32'hF0F0FF00};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        op        = 3'd0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_rdy%0d", i), 32'(in_rdy[i]), 32'd1);
            chk($sformatf("rst_ovld%0d", i), 32'(out_vld[i]), 32'd0);
            chk($sformatf("rst_res%0d", i), res[i], 32'h0);
            chk($sformatf("rst_zero%0d", i), 32'(zro[i]), 32'd0);
        end

        // XOR basic and all-zero result
        run_op("xor_ff", 3'b010, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b1);
        run_op("xor_zero", 3'b010, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1'b1);

        for (int k = 0; k < 8; k++)
            run_op($sformatf("sweep_op%0d", k), 3'(k), 32'h0F0F00FF, 32'h00FF0F0F, sweep_exp[k], 1'b1);

        // Backpressure in DONE while the producer pushes new requests
        run_op("bp", 3'b000, 32'hFFFF0000, 32'h12345678, 32'h12340000, 1'b0);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            op       = 3'($urandom);
            step();
            chk($sformatf("bp_res_c%0d", c), res[0], 32'h12340000);
            chk($sformatf("bp_rdy_c%0d", c), 32'(in_rdy[0]), 32'd0);
            chk($sformatf("bp_ovld_c%0d", c), 32'(out_vld[0]), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_drain_rdy", 32'(in_rdy[0]), 32'd1);
        chk("bp_drain_ovld", 32'(out_vld[0]), 32'd0);
        step();
        chk("bp_no_accept", 32'(in_rdy[0]), 32'd1);

        // Reset two cycles into RUN drops the op
        in_valid = 1'b1;
        op       = 3'b010;
        a        = 32'h0000FFFF;
        b        = 32'h00FF00FF;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_rdy%0d", i), 32'(in_rdy[i]), 32'd1);
            chk($sformatf("midrst_ovld%0d", i), 32'(out_vld[i]), 32'd0);
            chk($sformatf("midrst_res%0d", i), res[i], 32'h0);
        end
        run_op("post_rst_xor", 3'b010, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFF00, 1'b1);

        // Operand a is zeroed right after accept inside run_op; result must use latched a
        run_op("latched_a", 3'b110, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
